if_stage_buf: RTL and testbench

IF_STAGE_BUF -- requirements
Module: if_stage_buf

---
 rtl/if_stage_buf.sv | 132 +++++++++++++
 tb/tb_if_stage_buf.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_buf.sv
// Instruction-fetch stage: issues in-order fetch requests within a bounded
// window, tags returned data with its PC and buffers it ahead of decode.
module if_stage_buf #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        br_valid,
   input  logic [31:0] br_pc,
   input  logic        ds_allowin,
   output logic        fs2ds_valid,
   output logic [63:0] fs2ds_bus
);

   localparam int QAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int QCW = $clog2(DEPTH + 1);
   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam int SW  = ((QCW > OCW) ? QCW : OCW) + 1;

   logic [31:0]    fetch_pc_reg;
   logic [63:0]    q_mem [DEPTH];
   logic [QAW-1:0] q_rd_ptr_reg, q_wr_ptr_reg;
   logic [QCW-1:0] q_cnt_reg, q_cnt_next;
   logic [31:0]    p_mem [MAX_OUT];
   logic [PAW-1:0] p_rd_ptr_reg, p_wr_ptr_reg;
   logic [OCW-1:0] out_cnt_reg, out_cnt_next;
   logic [OCW-1:0] cancel_cnt_reg, cancel_cnt_next;

   logic           redirect;
   logic [31:0]    redirect_pc;
   logic [OCW-1:0] live_cnt;
   logic [SW-1:0]  window_used;
   logic           addr_fire, data_fire, drop_data;
   logic           q_push, q_pop;

   assign redirect    = ex_valid | br_valid;
   assign redirect_pc = ex_valid ? ex_pc : br_pc;

   // Every live (non-cancelled) request already owns a queue slot, so the
   // queue can never be overrun by returning data.
   assign live_cnt    = out_cnt_reg - cancel_cnt_reg;
   assign window_used = SW'(q_cnt_reg) + SW'(live_cnt);

   assign inst_req  = ~reset & ~redirect
                      & (out_cnt_reg < OCW'(MAX_OUT))
                      & (window_used < SW'(DEPTH));
   assign inst_addr = fetch_pc_reg;

   assign addr_fire = inst_req & inst_addr_ok;
   assign data_fire = inst_data_ok & (out_cnt_reg != '0);
   assign drop_data = (cancel_cnt_reg != '0);
   assign q_push    = data_fire & ~drop_data & ~redirect;

   assign fs2ds_valid = ~reset & (q_cnt_reg != '0);
   assign fs2ds_bus   = fs2ds_valid ? q_mem[q_rd_ptr_reg] : 64'h0;
   assign q_pop       = fs2ds_valid & ds_allowin;

   always_comb begin
      out_cnt_next    = out_cnt_reg;
      cancel_cnt_next = cancel_cnt_reg;
      q_cnt_next      = q_cnt_reg;
      if (addr_fire)
         out_cnt_next = out_cnt_next + OCW'(1);
      if (data_fire)
         out_cnt_next = out_cnt_next - OCW'(1);
      // On redirect, whatever is still outstanding afterwards belongs to the
      // abandoned path, including requests cancelled by an earlier redirect.
      if (redirect)
         cancel_cnt_next = out_cnt_next;
      else if (data_fire && drop_data)
         cancel_cnt_next = cancel_cnt_reg - OCW'(1);
      if (redirect)
         q_cnt_next = '0;
      else if (q_push && !q_pop)
         q_cnt_next = q_cnt_reg + QCW'(1);
      else if (!q_push && q_pop)
         q_cnt_next = q_cnt_reg - QCW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg   <= RESET_PC;
         q_rd_ptr_reg   <= '0;
         q_wr_ptr_reg   <= '0;
         q_cnt_reg      <= '0;
         p_rd_ptr_reg   <= '0;
         p_wr_ptr_reg   <= '0;
         out_cnt_reg    <= '0;
         cancel_cnt_reg <= '0;
      end else begin
         out_cnt_reg    <= out_cnt_next;
         cancel_cnt_reg <= cancel_cnt_next;
         q_cnt_reg      <= q_cnt_next;
         if (redirect)
            fetch_pc_reg <= redirect_pc;
         else if (addr_fire)
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
         if (addr_fire)
            p_wr_ptr_reg <= (p_wr_ptr_reg == PAW'(MAX_OUT - 1)) ? '0 : p_wr_ptr_reg + PAW'(1);
         if (data_fire)
            p_rd_ptr_reg <= (p_rd_ptr_reg == PAW'(MAX_OUT - 1)) ? '0 : p_rd_ptr_reg + PAW'(1);
         if (redirect) begin
            q_rd_ptr_reg <= '0;
            q_wr_ptr_reg <= '0;
         end else begin
            if (q_push)
               q_wr_ptr_reg <= q_wr_ptr_reg + QAW'(1);
            if (q_pop)
               q_rd_ptr_reg <= q_rd_ptr_reg + QAW'(1);
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (!reset && addr_fire)
         p_mem[p_wr_ptr_reg] <= fetch_pc_reg;
      if (!reset && q_push)
         q_mem[q_wr_ptr_reg] <= {inst_rdata, p_mem[p_rd_ptr_reg]};
   end

endmodule

// File: tb/tb_if_stage_buf.sv
// Directed bench for if_stage_buf: a small in-order memory slave answers
// fetches with pc-derived instruction words; each scenario checks inline.
module tb_if_stage_buf;

   localparam logic [31:0] RPC = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'h0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = 32'h0;
   logic        br_valid = 1'b0;
   logic [31:0] br_pc = 32'h0;
   logic        ds_allowin = 1'b0;
   logic        fs2ds_valid;
   logic [63:0] fs2ds_bus;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   bit auto_addr = 1'b0;
   bit auto_data = 1'b0;
   logic [31:0] slave_q[$];
   logic [63:0] got_q[$];
   int          got_cyc[$];

   if_stage_buf #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .br_valid(br_valid), .br_pc(br_pc),
      .ds_allowin(ds_allowin), .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_A5A5;
   endfunction

   task automatic slave_drive();
      inst_addr_ok = auto_addr;
      inst_data_ok = auto_data && (slave_q.size() > 0);
      inst_rdata   = (slave_q.size() > 0) ? inst_of(slave_q[0]) : 32'h0;
   endtask

   task automatic tick();
      bit hs, dh, dv;
      logic [31:0] a;
      logic [63:0] b;
      #1;
      hs = (inst_req === 1'b1) && (inst_addr_ok === 1'b1);
      a  = inst_addr;
      dh = (inst_data_ok === 1'b1) && (slave_q.size() > 0);
      dv = (fs2ds_valid === 1'b1) && (ds_allowin === 1'b1);
      b  = fs2ds_bus;
      @(posedge clk);
      cyc++;
      #1;
      if (dh) void'(slave_q.pop_front());
      if (hs) begin
         slave_q.push_back(a);
         acc_cnt++;
      end
      if (dv) begin
         got_q.push_back(b);
         got_cyc.push_back(cyc);
         $display("cycle %0d deliver pc=%h inst=%h", cyc, b[31:0], b[63:32]);
      end
      slave_drive();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      auto_addr = 1'b0; auto_data = 1'b0; ds_allowin = 1'b0;
      ex_valid = 1'b0; br_valid = 1'b0;
      slave_q.delete();
      slave_drive();
      tick(); tick();
      slave_q.delete(); got_q.delete(); got_cyc.delete(); acc_cnt = 0;
      slave_drive();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      tick(); tick();
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", inst_req); end
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", fs2ds_valid); end
      total++; if (fs2ds_bus !== 64'h0) begin bad++; $display("FAIL rst_bus: got %h want 0", fs2ds_bus); end
      reset = 1'b0;
      #1;
      total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", inst_req); end
      total++; if (inst_addr !== RPC) begin bad++; $display("FAIL first_addr: got %h want %h", inst_addr, RPC); end
      // stray data_ok with nothing outstanding must be ignored
      inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
      tick();
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL stray_dok: got valid %b want 0", fs2ds_valid); end
      total++; if (inst_addr !== RPC) begin bad++; $display("FAIL hold_addr: got %h want %h", inst_addr, RPC); end
   endtask

   task automatic test_stream();
      do_reset();
      ds_allowin = 1'b1; auto_addr = 1'b1; auto_data = 1'b1; slave_drive();
      repeat (8) tick();
      total++;
      if (got_q.size() < 3) begin
         bad++; $display("FAIL stream_cnt: got %0d want >=3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++; if (got_q[i][31:0] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, got_q[i][31:0], RPC + 32'(4 * i)); end
            total++; if (got_q[i][63:32] !== inst_of(RPC + 32'(4 * i))) begin bad++; $display("FAIL stream_inst%0d: got %h want %h", i, got_q[i][63:32], inst_of(RPC + 32'(4 * i))); end
         end
         for (int i = 1; i < 3; i++) begin
            total++; if (got_cyc[i] - got_cyc[i-1] != 1) begin bad++; $display("FAIL stream_gap%0d: got %0d want 1", i, got_cyc[i] - got_cyc[i-1]); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      ds_allowin = 1'b0; auto_addr = 1'b1; auto_data = 1'b1; slave_drive();
      repeat (10) tick();
      total++; if (acc_cnt != 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", acc_cnt); end
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", inst_req); end
      total++; if (fs2ds_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", fs2ds_valid); end
      total++; if (fs2ds_bus[31:0] !== RPC) begin bad++; $display("FAIL bp_head: got %h want %h", fs2ds_bus[31:0], RPC); end
      ds_allowin = 1'b1;
      repeat (12) tick();
      total++;
      if (got_q.size() < 6) begin
         bad++; $display("FAIL bp_drain_cnt: got %0d want >=6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++; if (got_q[i] !== {inst_of(RPC + 32'(4 * i)), RPC + 32'(4 * i)}) begin bad++; $display("FAIL bp_order%0d: got %h want pc %h", i, got_q[i], RPC + 32'(4 * i)); end
         end
      end
   endtask

   task automatic test_redirect_inflight();
      do_reset();
      ds_allowin = 1'b1; auto_addr = 1'b1; auto_data = 1'b0; slave_drive();
      tick(); tick();
      total++; if (acc_cnt != 2) begin bad++; $display("FAIL rd_inflight: got %0d want 2", acc_cnt); end
      br_valid = 1'b1; br_pc = RPC + 32'h100;
      #1;
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rd_req: got %b want 0", inst_req); end
      tick();
      br_valid = 1'b0;
      #1;
      total++; if (inst_addr !== RPC + 32'h100) begin bad++; $display("FAIL rd_addr: got %h want %h", inst_addr, RPC + 32'h100); end
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL rd_flush: got %b want 0", fs2ds_valid); end
      auto_data = 1'b1; slave_drive();
      repeat (10) tick();
      total++;
      if (got_q.size() < 2) begin
         bad++; $display("FAIL rd_cnt: got %0d want >=2", got_q.size());
      end else begin
         total++; if (got_q[0] !== {inst_of(RPC + 32'h100), RPC + 32'h100}) begin bad++; $display("FAIL rd_first: got %h want pc %h", got_q[0], RPC + 32'h100); end
         total++; if (got_q[1][31:0] !== RPC + 32'h104) begin bad++; $display("FAIL rd_second: got %h want %h", got_q[1][31:0], RPC + 32'h104); end
      end
   endtask

   task automatic test_ex_priority();
      do_reset();
      ds_allowin = 1'b1; auto_addr = 1'b1; auto_data = 1'b1; slave_drive();
      repeat (3) tick();
      ex_valid = 1'b1; ex_pc = RPC + 32'h8000;
      br_valid = 1'b1; br_pc = RPC + 32'h100;
      #1;
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL ex_req: got %b want 0", inst_req); end
      tick();
      ex_valid = 1'b0; br_valid = 1'b0;
      #1;
      total++; if (inst_addr !== RPC + 32'h8000) begin bad++; $display("FAIL ex_addr: got %h want %h", inst_addr, RPC + 32'h8000); end
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL ex_flush: got %b want 0", fs2ds_valid); end
      got_q.delete(); got_cyc.delete();
      repeat (8) tick();
      total++;
      if (got_q.size() < 2) begin
         bad++; $display("FAIL ex_cnt: got %0d want >=2", got_q.size());
      end else begin
         total++; if (got_q[0][31:0] !== RPC + 32'h8000) begin bad++; $display("FAIL ex_first: got %h want %h", got_q[0][31:0], RPC + 32'h8000); end
         total++; if (got_q[1][31:0] !== RPC + 32'h8004) begin bad++; $display("FAIL ex_second: got %h want %h", got_q[1][31:0], RPC + 32'h8004); end
      end
   endtask

   task automatic test_redirect_pending();
      do_reset();
      ds_allowin = 1'b1; auto_addr = 1'b0; auto_data = 1'b1; slave_drive();
      tick();
      total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL pend_req: got %b want 1", inst_req); end
      total++; if (inst_addr !== RPC) begin bad++; $display("FAIL pend_stable: got %h want %h", inst_addr, RPC); end
      br_valid = 1'b1; br_pc = RPC + 32'h200;
      #1;
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL pend_rdreq: got %b want 0", inst_req); end
      tick();
      br_valid = 1'b0;
      #1;
      total++; if (inst_addr !== RPC + 32'h200) begin bad++; $display("FAIL pend_addr: got %h want %h", inst_addr, RPC + 32'h200); end
      total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL pend_resume: got %b want 1", inst_req); end
      auto_addr = 1'b1; slave_drive();
      repeat (6) tick();
      total++;
      if (got_q.size() < 1) begin
         bad++; $display("FAIL pend_cnt: got %0d want >=1", got_q.size());
      end else begin
         total++; if (got_q[0][31:0] !== RPC + 32'h200) begin bad++; $display("FAIL pend_first: got %h want %h", got_q[0][31:0], RPC + 32'h200); end
      end
   endtask

   task automatic test_double_redirect();
      do_reset();
      ds_allowin = 1'b1; auto_addr = 1'b1; auto_data = 1'b0; slave_drive();
      tick(); tick();
      br_valid = 1'b1; br_pc = RPC + 32'h100;
      tick();
      br_valid = 1'b0;
      auto_data = 1'b1; slave_drive();
      tick();
      auto_data = 1'b0; slave_drive();
      tick();
      total++; if (acc_cnt != 3) begin bad++; $display("FAIL dbl_accepted: got %0d want 3", acc_cnt); end
      br_valid = 1'b1; br_pc = RPC + 32'h300;
      tick();
      br_valid = 1'b0;
      auto_data = 1'b1; slave_drive();
      repeat (10) tick();
      total++;
      if (got_q.size() < 1) begin
         bad++; $display("FAIL dbl_cnt: got %0d want >=1", got_q.size());
      end else begin
         total++; if (got_q[0] !== {inst_of(RPC + 32'h300), RPC + 32'h300}) begin bad++; $display("FAIL dbl_first: got %h want pc %h", got_q[0], RPC + 32'h300); end
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      ds_allowin = 1'b0; auto_addr = 1'b1; auto_data = 1'b1; slave_drive();
      repeat (10) tick();
      ds_allowin = 1'b1; auto_data = 1'b0; slave_drive();
      repeat (3) tick();
      total++; if (acc_cnt != 6) begin bad++; $display("FAIL mid_inflight: got %0d want 6", acc_cnt); end
      total++; if (fs2ds_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", fs2ds_valid); end
      reset = 1'b1; auto_addr = 1'b0; ds_allowin = 1'b0; slave_drive();
      tick();
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", inst_req); end
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", fs2ds_valid); end
      total++; if (fs2ds_bus !== 64'h0) begin bad++; $display("FAIL mid_bus: got %h want 0", fs2ds_bus); end
      slave_q.delete(); slave_drive();
      reset = 1'b0;
      #1;
      total++; if (inst_addr !== RPC) begin bad++; $display("FAIL mid_addr: got %h want %h", inst_addr, RPC); end
      total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL mid_resume: got %b want 1", inst_req); end
      total++; if (fs2ds_valid !== 1'b0) begin bad++; $display("FAIL mid_empty: got %b want 0", fs2ds_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_ex_priority();
      test_redirect_pending();
      test_double_redirect();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
